// File: rtl/booth_multiplier_seq_if.sv
// Start/done handshake and operand/product bus for booth_multiplier_seq.
// Optional macro BOOTH_MULT_OVF_EN adds the registered ovf flag.
interface booth_multiplier_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;
`ifdef BOOTH_MULT_OVF_EN
  logic                 ovf;

  modport master (output start, a, b, input busy, done, p, ovf);
  modport slave  (input start, a, b, output busy, done, p, ovf);
`else
  modport master (output start, a, b, input busy, done, p);
  modport slave  (input start, a, b, output busy, done, p);
`endif
endinterface

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth signed multiplier, one recoding step per clock,
// full 2*WIDTH-bit product. Optional macro BOOTH_MULT_OVF_EN adds ovf,
// flagging products that do not fit in WIDTH signed bits.
module booth_multiplier_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  booth_multiplier_seq_if.slave bus
);

  localparam int unsigned AW = WIDTH + 1;            // accumulator holds -M for M = min
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     m_q, m_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              qm1_q, qm1_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PW-1:0]     p_q, p_d;
`ifdef BOOTH_MULT_OVF_EN
  logic              ovf_q, ovf_d;
  logic [WIDTH:0]    top_bits;
`endif

  logic [AW-1:0]     sum;
  logic [AW-1:0]     acc_sh;
  logic [WIDTH-1:0]  q_sh;
  logic [PW-1:0]     prod;

  // One Booth step: add/subtract M by {Q0,q_m1}, then arithmetic shift right.
  always_comb begin
    sum = acc_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
    acc_sh = {sum[AW-1], sum[AW-1:1]};
    q_sh   = {sum[0], q_q[WIDTH-1:1]};
    prod   = {acc_sh[WIDTH-1:0], q_sh};
  end

`ifdef BOOTH_MULT_OVF_EN
  // Product fits in WIDTH signed bits only if its upper WIDTH+1 bits agree.
  assign top_bits = prod[PW-1:WIDTH-1];
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    p_d     = p_q;
`ifdef BOOTH_MULT_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = {bus.a[WIDTH-1], bus.a};
          acc_d   = '0;
          q_d     = bus.b;
          qm1_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          p_d     = prod;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
`ifdef BOOTH_MULT_OVF_EN
          ovf_d   = ~((&top_bits) | ~(|top_bits));
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
`ifdef BOOTH_MULT_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      p_q     <= p_d;
`ifdef BOOTH_MULT_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.p    = p_q;
`ifdef BOOTH_MULT_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq at WIDTH = 4, 8 and 16.
module tb_booth_multiplier_seq;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  booth_multiplier_seq_if #(.WIDTH(4))  if4 ();
  booth_multiplier_seq_if #(.WIDTH(8))  if8 ();
  booth_multiplier_seq_if #(.WIDTH(16)) if16 ();

  booth_multiplier_seq #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
  booth_multiplier_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  booth_multiplier_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model helpers ----------------
  function automatic longint sx(input longint v, input int w);
    longint t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  function automatic logic ref_ovf(input longint prod, input int w);
    longint lim;
    lim = longint'(1) <<< (w - 1);
    return (prod < -lim) || (prod > lim - 1);
  endfunction

  // ---------------- DUT access by width ----------------
  task automatic set_in(input int w, input logic st, input longint a, input longint b);
    case (w)
      4:       begin if4.start  = st; if4.a  = 4'(a);  if4.b  = 4'(b);  end
      8:       begin if8.start  = st; if8.a  = 8'(a);  if8.b  = 8'(b);  end
      default: begin if16.start = st; if16.a = 16'(a); if16.b = 16'(b); end
    endcase
  endtask

  function automatic logic get_done(input int w);
    case (w)
      4:       return if4.done;
      8:       return if8.done;
      default: return if16.done;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      4:       return if4.busy;
      8:       return if8.busy;
      default: return if16.busy;
    endcase
  endfunction

  function automatic longint get_p(input int w);
    case (w)
      4:       return longint'($signed(if4.p));
      8:       return longint'($signed(if8.p));
      default: return longint'($signed(if16.p));
    endcase
  endfunction

`ifdef BOOTH_MULT_OVF_EN
  function automatic logic get_ovf(input int w);
    case (w)
      4:       return if4.ovf;
      8:       return if8.ovf;
      default: return if16.ovf;
    endcase
  endfunction
`endif

  // Start one operation and wait (bounded) for done; returns at the done sample.
  task automatic run_op(input int w, input longint a, input longint b,
                        output longint p, output int lat, output int bcnt,
                        output bit stable);
    longint p0;
    @(negedge clk);
    p0 = get_p(w);
    set_in(w, 1'b1, a, b);
    @(negedge clk);
    set_in(w, 1'b0, longint'($urandom), longint'($urandom));
    lat    = 1;
    bcnt   = 0;
    stable = 1'b1;
    while (get_done(w) !== 1'b1 && lat < 200) begin
      if (get_busy(w) === 1'b1) bcnt++;
      if (get_p(w) !== p0) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    p = get_p(w);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_in(4, 1'b0, 0, 0);
    set_in(8, 1'b0, 0, 0);
    set_in(16, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    for (int w = 4; w <= 16; w = w * 2) begin
      n_tests++;
      if (get_busy(w) !== 1'b0 || get_done(w) !== 1'b0 || get_p(w) !== 64'sd0) begin
        n_fail++;
        $display("FAIL reset_w%0d: busy=%b done=%b p=%0d, required 0/0/0",
                 w, get_busy(w), get_done(w), get_p(w));
      end
`ifdef BOOTH_MULT_OVF_EN
      n_tests++;
      if (get_ovf(w) !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ovf_w%0d: ovf=%b, required 0", w, get_ovf(w));
      end
`endif
    end
    rst = 1'b0;
  endtask

  task automatic test_basic4();
    longint p; int lat; int bcnt; bit st;
    run_op(4, 3, -2, p, lat, bcnt, st);
    n_tests++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL basic4_latency: done seen at sample %0d, required 5", lat);
    end
    n_tests++;
    if (p !== -64'sd6) begin
      n_fail++;
      $display("FAIL basic4_p: p=%0d, required -6", p);
    end
    n_tests++;
    if (bcnt !== 4 || get_busy(4) !== 1'b0) begin
      n_fail++;
      $display("FAIL basic4_busy: busy cycles=%0d busy_at_done=%b, required 4/0", bcnt, get_busy(4));
    end
`ifdef BOOTH_MULT_OVF_EN
    n_tests++;
    if (get_ovf(4) !== 1'b0) begin
      n_fail++;
      $display("FAIL basic4_ovf: ovf=%b, required 0", get_ovf(4));
    end
`endif
    @(negedge clk);
    n_tests++;
    if (get_done(4) !== 1'b0) begin
      n_fail++;
      $display("FAIL basic4_done_pulse: done=%b one cycle later, required 0", get_done(4));
    end
  endtask

  task automatic test_corner4();
    longint ta[3] = '{-8, -8, 0};
    longint tb[3] = '{-8, 7, -5};
    longint p; int lat; int bcnt; bit st;
    for (int i = 0; i < 3; i++) begin
      run_op(4, ta[i], tb[i], p, lat, bcnt, st);
      n_tests++;
      if (p !== ta[i] * tb[i]) begin
        n_fail++;
        $display("FAIL corner4_p: %0d*%0d gave %0d, required %0d", ta[i], tb[i], p, ta[i] * tb[i]);
      end
`ifdef BOOTH_MULT_OVF_EN
      n_tests++;
      if (get_ovf(4) !== ref_ovf(ta[i] * tb[i], 4)) begin
        n_fail++;
        $display("FAIL corner4_ovf: %0d*%0d ovf=%b, required %b",
                 ta[i], tb[i], get_ovf(4), ref_ovf(ta[i] * tb[i], 4));
      end
`endif
    end
  endtask

  task automatic test_start_held();
    longint opa[30];
    longint opb[30];
    logic   exp_done;
    repeat (3) @(negedge clk);
    for (int j = 0; j < 40; j++) begin
      if (j > 0) @(negedge clk);
      exp_done = (j >= 5) && ((j - 5) % 6 == 0) && ((j - 5) < 30);
      n_tests++;
      if (get_done(4) !== exp_done) begin
        n_fail++;
        $display("FAIL held_done_c%0d: done=%b, required %b", j, get_done(4), exp_done);
      end
      if (exp_done) begin
        n_tests++;
        if (get_p(4) !== opa[j - 5] * opb[j - 5]) begin
          n_fail++;
          $display("FAIL held_p_c%0d: p=%0d, required %0d", j, get_p(4), opa[j - 5] * opb[j - 5]);
        end
      end
      if (j < 30) begin
        opa[j] = sx(longint'($urandom), 4);
        opb[j] = sx(longint'($urandom), 4);
        set_in(4, 1'b1, opa[j], opb[j]);
      end else begin
        set_in(4, 1'b0, 0, 0);
      end
    end
  endtask

  task automatic test_reset_midop();
    longint p; int lat; int bcnt; bit st; int dcnt;
    @(negedge clk);
    set_in(8, 1'b1, 100, -3);
    @(negedge clk);
    set_in(8, 1'b0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (get_busy(8) !== 1'b0 || get_done(8) !== 1'b0 || get_p(8) !== 64'sd0) begin
      n_fail++;
      $display("FAIL midop_reset: busy=%b done=%b p=%0d, required 0/0/0",
               get_busy(8), get_done(8), get_p(8));
    end
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (get_done(8) === 1'b1) dcnt++;
    end
    n_tests++;
    if (dcnt !== 0) begin
      n_fail++;
      $display("FAIL midop_no_done: %0d done pulses after abort, required 0", dcnt);
    end
    run_op(8, 100, -3, p, lat, bcnt, st);
    n_tests++;
    if (p !== -64'sd300 || lat !== 9) begin
      n_fail++;
      $display("FAIL midop_restart: p=%0d latency=%0d, required -300/9", p, lat);
    end
  endtask

  task automatic test_random(input int w, input int n);
    longint corner[5];
    longint a, b, p, lim;
    int lat; int bcnt; bit st;
    lim = longint'(1) <<< (w - 1);
    corner = '{0, 1, -1, lim - 1, -lim};
    for (int i = 0; i < n; i++) begin
      if (i < 25) begin
        a = corner[i / 5];
        b = corner[i % 5];
      end else begin
        a = sx(longint'($urandom), w);
        b = sx(longint'($urandom), w);
      end
      run_op(w, a, b, p, lat, bcnt, st);
      n_tests++;
      if (p !== a * b || lat !== w + 1) begin
        n_fail++;
        $display("FAIL rand_w%0d: %0d*%0d gave %0d latency %0d, required %0d latency %0d",
                 w, a, b, p, lat, a * b, w + 1);
      end
      n_tests++;
      if (st !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_stable_w%0d: p changed before done (%0d*%0d)", w, a, b);
      end
`ifdef BOOTH_MULT_OVF_EN
      n_tests++;
      if (get_ovf(w) !== ref_ovf(a * b, w)) begin
        n_fail++;
        $display("FAIL rand_ovf_w%0d: %0d*%0d ovf=%b, required %b", w, a, b, get_ovf(w), ref_ovf(a * b, w));
      end
`endif
    end
  endtask

  task automatic test_ignore_start();
    int lat; int dcnt;
    repeat (2) @(negedge clk);
    set_in(4, 1'b1, 5, 5);
    @(negedge clk);
    set_in(4, 1'b0, 5, 5);
    @(negedge clk);
    set_in(4, 1'b1, 7, 7);
    @(negedge clk);
    set_in(4, 1'b0, 0, 0);
    lat = 0;
    while (get_done(4) !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (get_done(4) !== 1'b1 || get_p(4) !== 64'sd25) begin
      n_fail++;
      $display("FAIL ignore_busy: done=%b p=%0d, required 1/25", get_done(4), get_p(4));
    end
    set_in(4, 1'b1, 3, 3);
    @(negedge clk);
    set_in(4, 1'b0, 0, 0);
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (get_done(4) === 1'b1) dcnt++;
    end
    n_tests++;
    if (dcnt !== 0 || get_p(4) !== 64'sd25) begin
      n_fail++;
      $display("FAIL ignore_done: extra done=%0d p=%0d, required 0/25", dcnt, get_p(4));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    test_reset();
    test_basic4();
    test_corner4();
    test_start_held();
    test_reset_midop();
    test_random(8, 1000);
    test_random(16, 1000);
    test_ignore_start();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_multiplier_seq.md
Name: booth_multiplier_seq

Overview:
Parametrised sequential two's-complement multiplier and the next generation of our 4-bit combinational signed multiplier. It uses radix-2 Booth recoding, one iteration per clock, and a start/done handshake. It returns the full 2*WIDTH-bit signed product. It trades latency for area in the wider datapath stages, where a combinational partial-product array is too large.

Parameters:
WIDTH, 8, operand width in bits (signed); legal range 2..32; product width is 2*WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request a multiply; sampled only in IDLE
a  input  WIDTH  multiplicand, signed; sampled with start
b  input  WIDTH  multiplier, signed; sampled with start
busy  output  1  high while an operation is in progress (BUSY state)
done  output  1  one-cycle pulse, high when p holds a new product
p  output  2*WIDTH  signed product a*b; registered, holds its value until the next done

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk. All state changes on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, p=0, all internal registers 0.
- States: IDLE, BUSY, DONE.
- IDLE, start=1 at edge t0:
  - Latch M=a, sign-extended to WIDTH+1 bits.
  - Load Q=b, A=0 (WIDTH+1 bits), q_m1=0, count=WIDTH.
  - Go to BUSY; busy=1 from t0.
- IDLE, start=0: stay in IDLE.
- BUSY, each edge t1..tWIDTH, one Booth step:
  - {Q[0],q_m1}=01: A=A+M.
  - {Q[0],q_m1}=10: A=A-M.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,q_m1} by 1, replicating the A MSB.
  - count decrements by 1.
- A is WIDTH+1 bits so that M=-2^(WIDTH-1) negates without overflow. All adds are modulo 2^(WIDTH+1).
- Edge on which count reaches 0 (tWIDTH):
  - p={A[WIDTH-1:0],Q}, which equals the exact signed product.
  - done=1, busy=0, go to DONE.
- DONE, next edge: done=0, go to IDLE. p holds.
- Latency: done is high in the cycle after edge t0+WIDTH. Start-to-start throughput is WIDTH+2 cycles.
- start while in BUSY or DONE is ignored; it is not queued. a and b may change freely after t0.
- start held high continuously: a new operation is accepted on each IDLE cycle, i.e. every WIDTH+2 cycles.
- rst asserted in any state aborts the operation:
  - Outputs return to reset values on that edge.
  - No done pulse is issued for the aborted operation.
- Boundary cases are all exact: a=0 or b=0 gives p=0; -2^(WIDTH-1) * -2^(WIDTH-1) gives +2^(2*WIDTH-2).
- p changes only on the done edge or on reset.

Optional Feature:
Macro BOOTH_MULT_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered.
  - ovf updates on the same edge as p.
  - ovf=1 when the product is not representable in WIDTH signed bits, i.e. p[2*WIDTH-1:WIDTH-1] is not all-equal; otherwise 0.
  - Resets to 0; holds with p.
  - Lets the block replace the legacy WIDTH-bit truncating multiplier with overflow detection.
- Not defined: port ovf and its logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=4: a=3, b=-2 (4'hE) -> done pulses exactly 4 edges after the start edge, for one cycle; p=8'hFA (-6); busy high during iterations only; ovf=0 if enabled.
2. WIDTH=4: a=-8, b=-8 -> p=8'h40 (+64), ovf=1. Then a=-8, b=7 -> p=8'hC8 (-56), ovf=1. Then a=0, b=-5 -> p=0, ovf=0.
3. WIDTH=4, start held high for 30 cycles with a, b changing every cycle -> operations accepted only on IDLE cycles, one every 6 cycles. Each p matches the operands sampled on its accept edge.
4. Reset mid-op: WIDTH=8, a=100, b=-3, assert rst for one cycle at the 3rd BUSY edge -> busy=0, done=0, p=0 after that edge; no done pulse follows. A new start then gives p=-300 (16'hFED4).
5. WIDTH=8 and WIDTH=16, 2000 random signed operand pairs including corner values (0, 1, -1, max, min) -> p equals the reference signed a*b. p is stable between done pulses.
6. start pulsed during BUSY and during DONE (WIDTH=4, a=5, b=5) -> ignored; p=8'h19 (25); no extra done pulse.
